// File: rtl/norm2_loader.sv
// rtl/norm2_loader.sv - streams N samples into the norm2 array, starts norm2, returns its result
module norm2_loader #(
    parameter int N  = 1000,
    parameter int AW = 10,
    parameter int DW = 27
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 s_valid,
    input  logic signed [DW-1:0] s_data,
    output logic                 s_ready,

    output logic                 controlArr,
    output logic                 controlArrWEnable_a,
    output logic [AW-1:0]        controlArrAddr_a,
    output logic signed [DW-1:0] controlArrWData_a,

    output logic                 r_enable,
    output logic [63:0]          init_i,
    output logic [63:0]          init_acc,
    input  logic                 w_enable,
    input  logic [63:0]          result,

    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [63:0]          res_data,
    output logic [31:0]          res_cycles
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_START  = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_RESULT = 3'd4;

    localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);

    logic [2:0]    state;
    logic [AW-1:0] wr_idx;
    logic          loading;
    logic          accept;

    // The host owns the array only while samples are being collected; reset
    // forces the host-owned view so the array is never left with norm2.
    assign loading  = (state == S_IDLE) || (state == S_LOAD);
    assign s_ready  = loading && !rst;
    assign accept   = s_valid && s_ready;

    assign controlArr          = loading || rst;
    assign controlArrWEnable_a = accept;
    assign controlArrAddr_a    = wr_idx;
    assign controlArrWData_a   = s_data;

    // Start pulse is the START state itself, masked while reset is asserted.
    assign r_enable = (state == S_START) && !rst;
    assign init_i   = 64'd0;
    assign init_acc = 64'd0;

    // Main sequencer: load, start, wait for done, hold result until taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            wr_idx     <= '0;
            res_valid  <= 1'b0;
            res_data   <= 64'd0;
            res_cycles <= 32'd0;
        end else begin
            case (state)
                S_IDLE, S_LOAD: begin
                    if (accept) begin
                        if (wr_idx == LAST_IDX) begin
                            wr_idx <= '0;
                            state  <= S_START;
                        end else begin
                            wr_idx <= wr_idx + 1'b1;
                            state  <= S_LOAD;
                        end
                    end
                end
                S_START: begin
                    res_cycles <= 32'd0;
                    state      <= S_WAIT;
                end
                S_WAIT: begin
                    if (res_cycles != 32'hFFFF_FFFF) begin
                        res_cycles <= res_cycles + 32'd1;
                    end
                    if (w_enable) begin
                        res_data  <= result;
                        res_valid <= 1'b1;
                        state     <= S_RESULT;
                    end
                end
                S_RESULT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    wr_idx    <= '0;
                    res_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_norm2_loader.sv
// tb/tb_norm2_loader.sv - directed self-checking bench for norm2_loader
module tb_norm2_loader;

    localparam int N   = 1000;
    localparam int AW  = 10;
    localparam int DW  = 27;
    localparam int LAT = 5;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 s_valid = 1'b0;
    logic signed [DW-1:0] s_data = '0;
    logic                 s_ready;
    logic                 controlArr;
    logic                 controlArrWEnable_a;
    logic [AW-1:0]        controlArrAddr_a;
    logic signed [DW-1:0] controlArrWData_a;
    logic                 r_enable;
    logic [63:0]          init_i;
    logic [63:0]          init_acc;
    logic                 w_enable = 1'b0;
    logic [63:0]          result = 64'd0;
    logic                 res_valid;
    logic                 res_ready = 1'b0;
    logic [63:0]          res_data;
    logic [31:0]          res_cycles;

    int checks = 0;
    int errors = 0;

    logic signed [DW-1:0] mem [N];
    int  exp_addr  = 0;
    int  wr_count  = 0;
    int  ren_count = 0;
    logic rst_prev = 1'b1;

    norm2_loader #(.N(N), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .controlArr(controlArr),
        .controlArrWEnable_a(controlArrWEnable_a),
        .controlArrAddr_a(controlArrAddr_a),
        .controlArrWData_a(controlArrWData_a),
        .r_enable(r_enable), .init_i(init_i), .init_acc(init_acc),
        .w_enable(w_enable), .result(result),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_cycles(res_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Array write monitor and pulse counter, sampled mid-cycle.
    always @(negedge clk) begin
        if (controlArrWEnable_a !== 1'b0 || (s_valid && s_ready) !== 1'b0)
            check("we_on_handshake", controlArrWEnable_a, s_valid && s_ready);
        if (controlArrWEnable_a === 1'b1) begin
            check("wr_addr", controlArrAddr_a, exp_addr);
            check("wr_owner", controlArr, 1);
            check("wr_data", controlArrWData_a, s_data);
            mem[controlArrAddr_a] = controlArrWData_a;
            exp_addr = (exp_addr == N - 1) ? 0 : exp_addr + 1;
            wr_count++;
        end
        if (r_enable === 1'b1) begin
            ren_count++;
            check("r_en_near_rst", {rst, rst_prev}, 0);
        end
        if (rst) exp_addr = 0;
        rst_prev = rst;
    end

    // norm2 model: computes from the array, holds done high until restarted.
    always begin
        logic [63:0] acc;
        @(negedge clk);
        if (r_enable === 1'b1) begin
            acc = 64'd0;
            for (int i = 0; i < N; i++)
                acc = acc + 64'(longint'(mem[i]) * longint'(mem[i]));
            @(posedge clk);
            #1;
            w_enable = 1'b0;
            repeat (LAT - 1) @(posedge clk);
            #1;
            result   = acc;
            w_enable = 1'b1;
        end
    end

    task automatic drive_word(input logic signed [DW-1:0] d, input int gap);
        repeat (gap) begin
            s_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        s_valid = 1'b1;
        s_data  = d;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic run_block(input int mode, input logic signed [DW-1:0] val,
                             input bit gapped, input int hold, input logic [63:0] exp_sum);
        int base_ren;
        int wait_n;
        int g;
        logic signed [DW-1:0] d;
        wr_count = 0;
        base_ren = ren_count;
        for (int k = 0; k < N; k++) begin
            g = gapped ? int'($urandom_range(0, 2)) : 0;
            d = (mode == 1) ? DW'(k - 500) : val;
            drive_word(d, g);
        end
        check("start_r_enable", r_enable, 1);
        check("start_s_ready", s_ready, 0);
        check("start_owner", controlArr, 0);
        s_valid = 1'b1;
        s_data  = DW'(12345);
        #1;
        check("start_no_write", controlArrWEnable_a, 0);
        wait_n = 0;
        while (res_valid !== 1'b1 && wait_n < 200) begin
            @(posedge clk);
            #1;
            wait_n++;
        end
        check("res_valid_seen", res_valid, 1);
        check("res_data", res_data, exp_sum);
        check("res_cycles", res_cycles, LAT);
        check("wr_count", wr_count, N);
        check("r_enable_pulses", ren_count, base_ren + 1);
        check("result_s_ready", s_ready, 0);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            check("hold_valid", res_valid, 1);
            check("hold_data", res_data, exp_sum);
            check("hold_cycles", res_cycles, LAT);
            check("hold_s_ready", s_ready, 0);
        end
        s_valid   = 1'b0;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        check("done_valid", res_valid, 0);
        check("done_s_ready", s_ready, 1);
        check("done_owner", controlArr, 1);
        check("done_pulses", ren_count, base_ren + 1);
    endtask

    initial begin
        int base_ren;
        rst     = 1'b1;
        s_valid = 1'b1;
        s_data  = DW'(5);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 0);
        check("rst_res_cycles", res_cycles, 0);
        check("rst_r_enable", r_enable, 0);
        check("rst_we", controlArrWEnable_a, 0);
        check("rst_owner", controlArr, 1);
        check("init_i", init_i, 0);
        check("init_acc", init_acc, 0);
        s_valid = 1'b0;
        rst     = 1'b0;
        #1;
        check("idle_s_ready", s_ready, 1);

        run_block(0, DW'(1), 1'b0, 0, 64'd1000);
        run_block(1, '0, 1'b1, 50, 64'd83333500);
        run_block(0, DW'(-(1 << 26)), 1'b0, 0, 64'd4503599627370496000);

        base_ren = ren_count;
        for (int k = 0; k < 400; k++) drive_word(DW'(7), 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("abort_no_pulse", ren_count, base_ren);
        check("abort_s_ready", s_ready, 1);
        run_block(0, DW'(2), 1'b0, 0, 64'd4000);

        run_block(0, DW'(1), 1'b0, 0, 64'd1000);
        run_block(0, DW'(3), 1'b1, 0, 64'd9000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
